// File: rtl/sum_3_inv.sv
// Inverse 3-tap moving sum: recovers x[n] = y[n] - x[n-1] - x[n-2] (mod 2^W), with a sticky range fault.
// Optional macro SUM3_INV_CNT_EN adds sample_cnt / fault_cnt status counters.
module sum_3_inv #(
  parameter int W      = 8,
  parameter int LIM_HI = 127,
  parameter int LIM_LO = -128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] in,
  output logic signed [W-1:0] out,
  output logic                out_valid,
  output logic                fault
`ifdef SUM3_INV_CNT_EN
  ,
  output logic [15:0]         sample_cnt,
  output logic [7:0]          fault_cnt
`endif
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] h1_q, h1_d;
  logic signed [W-1:0] h2_q, h2_d;
  logic signed [W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] r;
  logic                in_range;

  // Wrapping subtraction in W bits is what makes recovery exact after encoder overflow.
  assign r        = in - h1_q - h2_q;
  assign in_range = (int'(r) >= LIM_LO) && (int'(r) <= LIM_HI);

  always_comb begin
    state_d     = state_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (clr) begin
      state_d = RUN;
      h1_d    = '0;
      h2_d    = '0;
      out_d   = '0;
    end else if (en && state_q == RUN) begin
      if (!in_range) begin
        // A bad sample means the history is already out of step; do not let it in.
        state_d = FAULT;
      end else begin
        out_d       = r;
        h1_d        = r;
        h2_d        = h1_q;
        out_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments and only here, so every
  // flop samples the same pre-edge values computed in the always_comb above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      h1_q        <= '0;
      h2_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign fault     = (state_q == FAULT);

`ifdef SUM3_INV_CNT_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [7:0]  fault_cnt_q, fault_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q + 16'(out_valid_d);
    fault_cnt_d  = fault_cnt_q;
    if (state_q == RUN && state_d == FAULT && fault_cnt_q != 8'hFF)
      fault_cnt_d = fault_cnt_q + 8'd1;
  end

  // Counters survive clr so software can see activity across link resyncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign fault_cnt  = fault_cnt_q;
`endif

endmodule

// File: tb/tb_sum_3_inv.sv
// Scoreboard bench for sum_3_inv: dut_a uses default limits, dut_b uses +/-50 to exercise the fault path.
module tb_sum_3_inv;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr_a, clr_b, en_a, en_b;
  logic signed [7:0] in_s;
  logic signed [7:0] out_a, out_b;
  logic              out_valid_a, out_valid_b, fault_a, fault_b;
`ifdef SUM3_INV_CNT_EN
  logic [15:0]       sample_cnt_a, sample_cnt_b;
  logic [7:0]        fault_cnt_a, fault_cnt_b;
`endif

  int checks   = 0;
  int failures = 0;

  logic signed [7:0] exp_a[$];
  logic signed [7:0] exp_b[$];

  always #5 clk = ~clk;

  sum_3_inv #(.W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .en(en_a), .in(in_s),
    .out(out_a), .out_valid(out_valid_a), .fault(fault_a)
`ifdef SUM3_INV_CNT_EN
    , .sample_cnt(sample_cnt_a), .fault_cnt(fault_cnt_a)
`endif
  );

  sum_3_inv #(.W(8), .LIM_HI(50), .LIM_LO(-50)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .en(en_b), .in(in_s),
    .out(out_b), .out_valid(out_valid_b), .fault(fault_b)
`ifdef SUM3_INV_CNT_EN
    , .sample_cnt(sample_cnt_b), .fault_cnt(fault_cnt_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitors: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid_a) begin
      if (exp_a.size() == 0) check("a_unexpected_valid", {24'd0, out_a}, 32'hDEAD);
      else check("a_out", {24'd0, out_a}, {24'd0, exp_a.pop_front()});
    end
    if (rst_n && out_valid_b) begin
      if (exp_b.size() == 0) check("b_unexpected_valid", {24'd0, out_b}, 32'hDEAD);
      else check("b_out", {24'd0, out_b}, {24'd0, exp_b.pop_front()});
      if (fault_b) check("b_valid_with_fault", 32'd1, 32'd0);
    end
  end

  task automatic send_a(input logic signed [7:0] v, input bit has_exp, input logic signed [7:0] e);
    in_s = v;
    en_a = 1'b1;
    if (has_exp) exp_a.push_back(e);
    @(negedge clk);
    en_a = 1'b0;
  endtask

  task automatic send_b(input logic signed [7:0] v, input bit has_exp, input logic signed [7:0] e);
    in_s = v;
    en_b = 1'b1;
    if (has_exp) exp_b.push_back(e);
    @(negedge clk);
    en_b = 1'b0;
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0; en_a = 1'b0; en_b = 1'b0; in_s = '0;
    repeat (2) @(negedge clk);
    check("rst_out_a", {24'd0, out_a}, 32'd0);
    check("rst_valid_a", {31'd0, out_valid_a}, 32'd0);
    check("rst_fault_a", {31'd0, fault_a}, 32'd0);
    check("rst_fault_b", {31'd0, fault_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic decode: 5,15,12 -> 5,10,-3
    send_a(8'sd5,  1, 8'sd5);
    send_a(8'sd15, 1, 8'sd10);
    send_a(8'sd12, 1, -8'sd3);
    repeat (2) @(negedge clk);
    check("basic_hold_out", {24'd0, out_a}, {24'd0, 8'hFD});

    // Wrap: encoder of 100,100,100 emits 100,-56,44
    pulse_clr_a();
    check("clr_out_zero", {24'd0, out_a}, 32'd0);
    send_a(8'sd100, 1, 8'sd100);
    send_a(-8'sd56, 1, 8'sd100);
    send_a(8'sd44,  1, 8'sd100);
    @(negedge clk);
    check("wrap_fault_low", {31'd0, fault_a}, 32'd0);

    // clr/en collision: the sample is discarded
    pulse_clr_a();
    clr_a = 1'b1; en_a = 1'b1; in_s = 8'sd9;
    @(negedge clk);
    clr_a = 1'b0; en_a = 1'b0;
    check("collide_out_zero", {24'd0, out_a}, 32'd0);
    check("collide_no_valid", {31'd0, out_valid_a}, 32'd0);
    send_a(8'sd4, 1, 8'sd4);
    @(negedge clk);

    // Idle hold: 10 cycles of en=0 with toggling input
    pulse_clr_a();
    send_a(8'sd5,  1, 8'sd5);
    send_a(8'sd15, 1, 8'sd10);
    for (int i = 0; i < 10; i++) begin
      in_s = (i % 2 == 0) ? 8'sd77 : -8'sd33;
      @(negedge clk);
      check("idle_no_valid", {31'd0, out_valid_a}, 32'd0);
    end
    send_a(8'sd12, 1, -8'sd3);
    @(negedge clk);

    // Fault and clear on dut_b (limits +/-50)
    send_b(8'sd5,  1, 8'sd5);
    send_b(8'sd15, 1, 8'sd10);
    send_b(8'sd12, 1, -8'sd3);
    send_b(8'sd127, 0, 8'sd0);
    check("fault_set", {31'd0, fault_b}, 32'd1);
    check("fault_no_valid", {31'd0, out_valid_b}, 32'd0);
    check("fault_out_held", {24'd0, out_b}, {24'd0, 8'hFD});
    send_b(8'sd1, 0, 8'sd0);
    check("fault_sticky", {31'd0, fault_b}, 32'd1);
    check("fault_en_ignored", {24'd0, out_b}, {24'd0, 8'hFD});
`ifdef SUM3_INV_CNT_EN
    check("cnt_samples_pre", {16'd0, sample_cnt_b}, 32'd3);
    check("cnt_faults_pre", {24'd0, fault_cnt_b}, 32'd1);
`endif
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    check("clr_fault_cleared", {31'd0, fault_b}, 32'd0);
    check("clr_b_out_zero", {24'd0, out_b}, 32'd0);
    send_b(8'sd7, 1, 8'sd7);
    send_b(8'sd8, 1, 8'sd1);
    @(negedge clk);
`ifdef SUM3_INV_CNT_EN
    check("cnt_samples", {16'd0, sample_cnt_b}, 32'd5);
    check("cnt_faults", {24'd0, fault_cnt_b}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("cnt_samples_rst", {16'd0, sample_cnt_b}, 32'd0);
    check("cnt_faults_rst", {24'd0, fault_cnt_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    check("a_queue_drained", exp_a.size(), 32'd0);
    check("b_queue_drained", exp_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
